// File: rtl/rr_arb_pipeline_pkg.sv
// Shared types and helpers for the round-robin arbitrated register pipeline.
// Stage record layout; a macro because package typedefs cannot take parameters.
`define RR_STAGE_T(CHW, W) struct packed { logic valid; logic [(CHW)-1:0] ch; logic [(W)-1:0] data; }

package rr_pipe_pkg;

   // Channel tag width; a single channel still carries a one-bit (always zero) tag.
   function automatic int ch_w(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

   // Pointer after an accept of channel g; an out-of-range g means no accept and ptr holds.
   function automatic int unsigned rr_next(input int unsigned ptr,
                                           input int unsigned g,
                                           input int unsigned num_ch);
      return (g < num_ch) ? ((g + 1) % num_ch) : ptr;
   endfunction

endpackage

// File: rtl/rr_arb_pipeline_if.sv
// Producer/consumer handshake bundle around the arbitrated pipeline.
interface rr_arb_pipeline_if #(
   parameter int NUM_CH = 4,
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 3
);
   localparam int CH_W  = rr_pipe_pkg::ch_w(NUM_CH);
   localparam int OCC_W = $clog2(DEPTH + 1);

   logic [NUM_CH-1:0]       in_valid;
   logic [NUM_CH-1:0]       in_ready;
   logic [NUM_CH*WIDTH-1:0] in_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [WIDTH-1:0]        out_data;
   logic [CH_W-1:0]         out_ch;
   logic [OCC_W-1:0]        occupancy;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_ch, occupancy
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_ch, occupancy
   );
endinterface

// File: rtl/rr_arb_pipeline_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping modulo NUM_CH.
module rr_arbiter
   import rr_pipe_pkg::*;
#(
   parameter  int NUM_CH = 4,
   localparam int CH_W   = ch_w(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req_i,
   input  logic [CH_W-1:0]   ptr_i,
   output logic [NUM_CH-1:0] gnt_o,
   output logic [CH_W-1:0]   idx_o,
   output logic              any_o
);

   always_comb begin
      int cand;
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      cand  = 0;
      for (int k = 0; k < NUM_CH; k++) begin
         cand = int'((32'(ptr_i) + 32'(k)) % 32'(NUM_CH));
         if (!any_o && req_i[cand]) begin
            any_o       = 1'b1;
            gnt_o[cand] = 1'b1;
            idx_o       = CH_W'(cand);
         end
      end
   end

endmodule

// File: rtl/rr_arb_pipeline.sv
// Round-robin arbitrated register pipeline: NUM_CH producers share one DEPTH-stage valid/ready pipe.
module rr_arb_pipeline
   import rr_pipe_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 3
) (
   input logic              clk,
   input logic              rst,
   rr_arb_pipeline_if.slave bus
);

   localparam int CH_W  = ch_w(NUM_CH);
   localparam int OCC_W = $clog2(DEPTH + 1);

   typedef `RR_STAGE_T(CH_W, WIDTH) stage_t;

   logic [CH_W-1:0]   ptr_q, ptr_d;
   logic [OCC_W-1:0]  occ_q, occ_d;
   logic [NUM_CH-1:0] gnt;
   logic [CH_W-1:0]   gidx;
   logic              any_req;
   logic              accept;
   logic [DEPTH-1:0]  vld_q;
   logic [DEPTH-1:0]  vld_d;
   logic [DEPTH-1:0]  adv;
   stage_t            in_beat;
   stage_t            stage_q [DEPTH];

   rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
      .req_i (bus.in_valid),
      .ptr_i (ptr_q),
      .gnt_o (gnt),
      .idx_o (gidx),
      .any_o (any_req)
   );

   // rst gates the grant so nothing is offered a ready while the block is held in reset.
   assign accept       = any_req & adv[0] & rst;
   assign bus.in_ready = gnt & {NUM_CH{adv[0] & rst}};

   always_comb begin
      in_beat       = '0;
      in_beat.valid = accept;
      in_beat.ch    = gidx;
      in_beat.data  = bus.in_data[32'(gidx)*WIDTH +: WIDTH];
   end

   assign ptr_d = CH_W'(rr_next(32'(ptr_q), accept ? 32'(gidx) : 32'(NUM_CH), 32'(NUM_CH)));
   assign occ_d = OCC_W'($countones(vld_d));

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      stage_t src;
      stage_t st_d;
      stage_t st_q;

      if (gi == 0) begin : g_head
         assign src = in_beat;
      end else begin : g_body
         assign src = stage_q[gi-1];
      end

      // Flattened stall chain: a stage moves unless it and every stage after it are full and stalled.
      assign adv[gi] = bus.out_ready | ~(&vld_q[DEPTH-1:gi]);

      // Tag and data only follow valid beats, so an emptied stage keeps its last contents.
      always_comb begin
         st_d = st_q;
         if (adv[gi]) begin
            st_d.valid = src.valid;
            if (src.valid) begin
               st_d.ch   = src.ch;
               st_d.data = src.data;
            end
         end
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            st_q <= '0;
         end else begin
            st_q <= st_d;
         end
      end

      assign stage_q[gi] = st_q;
      assign vld_q[gi]   = st_q.valid;
      assign vld_d[gi]   = st_d.valid;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q <= '0;
         occ_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         occ_q <= occ_d;
      end
   end

   assign bus.out_valid = stage_q[DEPTH-1].valid;
   assign bus.out_data  = stage_q[DEPTH-1].data;
   assign bus.out_ch    = stage_q[DEPTH-1].ch;
   assign bus.occupancy = occ_q;

   a_ready_onehot: assert property (@(posedge clk) disable iff (!rst)
      $onehot0(bus.in_ready));

   a_out_stable: assert property (@(posedge clk) disable iff (!rst)
      (bus.out_valid && !bus.out_ready) |=>
         (bus.out_valid && $stable(bus.out_data) && $stable(bus.out_ch)));

endmodule

// File: tb/tb_rr_arb_pipeline.sv
// Scoreboard bench: directed stimulus queues expected beats, negedge monitors pop and compare.
module tb_rr_arb_pipeline;
   import rr_pipe_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [1:0] ch;
      logic [7:0] data;
   } beat_t;

   beat_t      qa [$];
   logic [7:0] qb [$];
   beat_t      exp_a;
   logic [7:0] exp_b;

   rr_arb_pipeline_if #(.NUM_CH(4), .WIDTH(8), .DEPTH(3)) ba ();
   rr_arb_pipeline_if #(.NUM_CH(1), .WIDTH(8), .DEPTH(1)) bb ();

   rr_arb_pipeline #(.NUM_CH(4), .WIDTH(8), .DEPTH(3)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ba.slave)
   );

   rr_arb_pipeline #(.NUM_CH(1), .WIDTH(8), .DEPTH(1)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bb.slave)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_a(input logic [1:0] ch, input logic [7:0] data);
      beat_t b;
      b.ch   = ch;
      b.data = data;
      qa.push_back(b);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Bounded drain: wait for the selected pipeline to empty, then realign after a posedge.
   task automatic wait_empty(input string name, input bit use_b);
      int n;
      n = 0;
      while (((use_b ? 32'(bb.occupancy) : 32'(ba.occupancy)) != 0) && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk(name, use_b ? 32'(bb.occupancy) : 32'(ba.occupancy), 32'd0);
      step();
   endtask

   // Monitor for the 4-channel build.
   always @(negedge clk) begin
      if (ba.out_valid && ba.out_ready) begin
         if (qa.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL a_unexpected_beat: got ch=%0d data=%02h expected no beat", ba.out_ch, ba.out_data);
         end else begin
            exp_a = qa.pop_front();
            chk("a_out_ch", 32'(ba.out_ch), 32'(exp_a.ch));
            chk("a_out_data", 32'(ba.out_data), 32'(exp_a.data));
            $display("a beat ch=%0d data=%02h", ba.out_ch, ba.out_data);
         end
      end
   end

   // Monitor for the single-channel build.
   always @(negedge clk) begin
      if (bb.out_valid && bb.out_ready) begin
         if (qb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL b_unexpected_beat: got data=%02h expected no beat", bb.out_data);
         end else begin
            exp_b = qb.pop_front();
            chk("b_out_ch", 32'(bb.out_ch), 32'd0);
            chk("b_out_data", 32'(bb.out_data), 32'(exp_b));
            $display("b beat ch=%0d data=%02h", bb.out_ch, bb.out_data);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not reach its summary");
      $fatal(1);
   end

   initial begin
      logic [7:0] v;
      int         k;
      bit         acc;

      ba.in_valid  = '0;
      ba.in_data   = '0;
      ba.out_ready = 1'b0;
      bb.in_valid  = '0;
      bb.in_data   = '0;
      bb.out_ready = 1'b0;

      // Reset held for two cycles with requests present: nothing may be granted.
      ba.in_valid = 4'hF;
      bb.in_valid = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 32'(ba.in_ready), 32'd0);
      chk("rst_out_valid", 32'(ba.out_valid), 32'd0);
      chk("rst_occupancy", 32'(ba.occupancy), 32'd0);
      chk("rst_out_data", 32'(ba.out_data), 32'd0);
      chk("rst_out_ch", 32'(ba.out_ch), 32'd0);
      chk("rst_b_in_ready", 32'(bb.in_ready), 32'd0);
      ba.in_valid = '0;
      bb.in_valid = '0;
      step();
      rst = 1'b1;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         chk("idle_in_ready", 32'(ba.in_ready), 32'd0);
         chk("idle_out_valid", 32'(ba.out_valid), 32'd0);
         chk("idle_occupancy", 32'(ba.occupancy), 32'd0);
      end
      step();

      // All four channels requesting: grants rotate 0,1,2,3 at one beat per cycle.
      ba.out_ready = 1'b1;
      for (int n = 0; n < 8; n++) begin
         ba.in_valid = 4'hF;
         for (int c = 0; c < 4; c++) ba.in_data[c*8 +: 8] = 8'(c * 16 + n);
         @(negedge clk);
         chk("rr_in_ready", 32'(ba.in_ready), 32'(1) << (n % 4));
         chk("rr_occupancy", 32'(ba.occupancy), 32'((n < 3) ? n : 3));
         chk("rr_out_valid", 32'(ba.out_valid), 32'(n >= 3));
         push_a(2'(n % 4), 8'((n % 4) * 16 + n));
         step();
      end
      ba.in_valid = '0;
      wait_empty("rr_drain", 1'b0);

      // Single beat from channel 1: visible at the output DEPTH cycles after acceptance.
      ba.in_valid = 4'b0010;
      ba.in_data  = 32'h0000_A500;
      @(negedge clk);
      chk("lat_in_ready", 32'(ba.in_ready), 32'h2);
      push_a(2'd1, 8'hA5);
      step();
      ba.in_valid = '0;
      for (int n = 1; n <= 3; n++) begin
         @(negedge clk);
         chk("lat_out_valid", 32'(ba.out_valid), 32'(n == 3));
         if (n == 1) chk("lat_occupancy", 32'(ba.occupancy), 32'd1);
      end
      wait_empty("lat_drain", 1'b0);

      // Channel 2 streams 1,2,3,... while the consumer stalls for six cycles.
      v = 8'd1;
      for (int n = 0; n < 10; n++) begin
         ba.out_ready = (n >= 6);
         ba.in_valid  = 4'b0100;
         ba.in_data   = {8'h00, v, 16'h0000};
         acc          = (n < 3) || (n >= 6);
         @(negedge clk);
         chk("stall_in_ready", 32'(ba.in_ready), acc ? 32'h4 : 32'h0);
         chk("stall_occupancy", 32'(ba.occupancy), 32'((n < 3) ? n : 3));
         chk("stall_out_valid", 32'(ba.out_valid), 32'(n >= 3));
         if (n >= 3) chk("stall_out_data", 32'(ba.out_data), 32'((n <= 6) ? 1 : n - 5));
         if (acc) begin
            push_a(2'd2, v);
            v = v + 8'd1;
         end
         step();
      end
      ba.in_valid  = '0;
      ba.out_ready = 1'b1;
      wait_empty("stall_drain", 1'b0);

      // Reset with two beats in flight: they are discarded and the pointer restarts at channel 0.
      ba.out_ready = 1'b0;
      ba.in_valid  = 4'b0001;
      for (int n = 0; n < 2; n++) begin
         ba.in_data = {24'h0, 8'(8'hE0 + n)};
         @(negedge clk);
         chk("mid_in_ready", 32'(ba.in_ready), 32'h1);
         step();
      end
      @(negedge clk);
      chk("mid_occupancy", 32'(ba.occupancy), 32'd2);
      rst = 1'b0;
      #1;
      chk("mid_rst_out_valid", 32'(ba.out_valid), 32'd0);
      chk("mid_rst_occupancy", 32'(ba.occupancy), 32'd0);
      chk("mid_rst_out_data", 32'(ba.out_data), 32'd0);
      chk("mid_rst_out_ch", 32'(ba.out_ch), 32'd0);
      chk("mid_rst_in_ready", 32'(ba.in_ready), 32'd0);
      step();
      rst          = 1'b1;
      ba.out_ready = 1'b1;
      ba.in_valid  = 4'hF;
      ba.in_data   = 32'h3322_1177;
      @(negedge clk);
      chk("mid_restart_grant", 32'(ba.in_ready), 32'h1);
      push_a(2'd0, 8'h77);
      step();
      ba.in_valid = '0;
      wait_empty("mid_drain", 1'b0);

      // Single-channel, single-stage build with out_ready toggling every cycle.
      k = 0;
      for (int n = 0; n < 10; n++) begin
         bb.out_ready = (n % 2 == 0);
         bb.in_valid  = 1'b1;
         bb.in_data   = 8'(8'h30 + k);
         acc          = (n % 2 == 0);
         @(negedge clk);
         chk("one_in_ready", 32'(bb.in_ready), 32'(acc));
         chk("one_occupancy", 32'(bb.occupancy), 32'(n >= 1));
         chk("one_out_valid", 32'(bb.out_valid), 32'(n >= 1));
         if (acc) begin
            qb.push_back(8'(8'h30 + k));
            k++;
         end
         step();
      end
      bb.in_valid  = 1'b0;
      bb.out_ready = 1'b1;
      wait_empty("one_drain", 1'b1);

      chk("a_queue_empty", 32'(qa.size()), 32'd0);
      chk("b_queue_empty", 32'(qb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
